// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants and capture FSM state type
package seg7_pkg;
  typedef logic [6:0] seg_t;
  typedef enum logic [1:0] {IDLE, SETTLE, ACCEPT, HOLD} cap_state_t;
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h18;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;
  localparam seg_t SEG_R = 7'h4E;
  localparam seg_t SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seg7_pattern_dec.sv
// seg7_pattern_dec: active-low gfedcba pattern to nibble, hex or extended alphabet
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  seg_t       i_seg,
  input  logic       i_extended,
  output logic [3:0] o_nibble,
  output logic       o_legal,
  output logic       o_blank
);
  logic w_hit;
  always_comb begin
    o_nibble = 4'h0;
    w_hit = 1'b1;
    if (i_extended)
      case (i_seg)
        SEG_A:   o_nibble = 4'hA;
        SEG_B:   o_nibble = 4'hB;
        SEG_R:   o_nibble = 4'hC;
        default: w_hit = 1'b0;
      endcase
    else
      case (i_seg)
        SEG_0:   o_nibble = 4'h0;
        SEG_1:   o_nibble = 4'h1;
        SEG_2:   o_nibble = 4'h2;
        SEG_3:   o_nibble = 4'h3;
        SEG_4:   o_nibble = 4'h4;
        SEG_5:   o_nibble = 4'h5;
        SEG_6:   o_nibble = 4'h6;
        SEG_7:   o_nibble = 4'h7;
        SEG_8:   o_nibble = 4'h8;
        SEG_9:   o_nibble = 4'h9;
        SEG_A:   o_nibble = 4'hA;
        SEG_B:   o_nibble = 4'hB;
        SEG_C:   o_nibble = 4'hC;
        SEG_D:   o_nibble = 4'hD;
        SEG_E:   o_nibble = 4'hE;
        SEG_F:   o_nibble = 4'hF;
        default: w_hit = 1'b0;
      endcase
  end
  assign o_blank = (i_seg == SEG_BLANK);
  assign o_legal = w_hit | o_blank;
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed active-low 7-segment bus, debounces scans
// and rebuilds the displayed per-digit nibbles with validity and timeout tracking.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [N_DIGITS-1:0]   an,
  input  logic                  extended,
  output logic [4*N_DIGITS-1:0] value,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic [N_DIGITS-1:0]   digit_blank,
  output logic                  changed,
  output logic                  frame_done,
  output logic                  pattern_err
);
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  seg_t                r_seg_sync [SYNC_STAGES];
  logic [N_DIGITS-1:0] r_an_sync  [SYNC_STAGES];
  cap_state_t          r_state;
  logic [DW-1:0]       r_digit;
  seg_t                r_seg_lat;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_val [N_DIGITS];
  logic [TW-1:0]       r_to  [N_DIGITS];
  logic [N_DIGITS-1:0] r_valid, r_blank, r_seen;
  logic                r_chg, r_frame, r_err;
  seg_t                w_seg;
  logic [N_DIGITS-1:0] w_an_n, w_sel, w_seen_nxt;
  logic [DW-1:0]       w_digit;
  logic                w_legal, w_same, w_acc, w_chg;
  logic [3:0]          w_nib;
  logic                w_pat_legal, w_pat_blank;
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_seg_sync[i] <= '1;
        r_an_sync[i]  <= '1;
      end
    end else begin
      r_seg_sync[0] <= seg;
      r_an_sync[0]  <= an;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_seg_sync[i] <= r_seg_sync[i-1];
        r_an_sync[i]  <= r_an_sync[i-1];
      end
    end
  assign w_seg   = r_seg_sync[SYNC_STAGES-1];
  assign w_an_n  = ~r_an_sync[SYNC_STAGES-1];
  // exactly one anode low; zero lows is idle, several is a ghost
  assign w_legal = (w_an_n != '0) && ((w_an_n & (w_an_n - N_DIGITS'(1))) == '0);
  always_comb begin
    w_digit = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (w_an_n[i]) w_digit = DW'(i);
  end
  assign w_same = w_legal && (w_digit == r_digit) && (w_seg == r_seg_lat);
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_digit   <= '0;
      r_seg_lat <= '1;
      r_cnt     <= '0;
    end else
      case (r_state)
        IDLE:
          if (w_legal) begin
            r_digit   <= w_digit;
            r_seg_lat <= w_seg;
            r_cnt     <= CW'(1);
            r_state   <= SETTLE;
          end
        SETTLE:
          if (r_cnt == CW'(STABLE_CYCLES)) r_state <= ACCEPT;
          else if (w_same) r_cnt <= r_cnt + CW'(1);
          else if (w_legal) begin
            r_digit   <= w_digit;
            r_seg_lat <= w_seg;
            r_cnt     <= CW'(1);
          end else r_state <= IDLE;
        ACCEPT: r_state <= HOLD;
        default:
          if (!w_same) begin
            r_digit   <= w_digit;
            r_seg_lat <= w_seg;
            r_cnt     <= CW'(1);
            r_state   <= w_legal ? SETTLE : IDLE;
          end
      endcase
  seg7_pattern_dec u_dec (
    .i_seg      (r_seg_lat),
    .i_extended (extended),
    .o_nibble   (w_nib),
    .o_legal    (w_pat_legal),
    .o_blank    (w_pat_blank)
  );
  assign w_acc      = (r_state == ACCEPT);
  assign w_sel      = N_DIGITS'(1) << r_digit;
  assign w_seen_nxt = r_seen | w_sel;
  assign w_chg      = w_pat_legal && ((!w_pat_blank && w_nib != r_val[r_digit]) || (w_pat_blank != r_blank[r_digit]));
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_valid <= '0;
      r_blank <= '0;
      r_seen  <= '0;
      r_chg   <= 1'b0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        r_val[i] <= '0;
        r_to[i]  <= '0;
      end
    end else begin
      r_chg   <= w_acc && w_chg;
      r_frame <= w_acc && (w_seen_nxt == '1);
      if (w_acc) begin
        r_seen <= (w_seen_nxt == '1) ? '0 : w_seen_nxt;
        if (!w_pat_legal) r_err <= 1'b1;
      end
      // an accept on a digit overrides its timeout in the same cycle
      for (int i = 0; i < N_DIGITS; i++)
        if (w_acc && r_digit == DW'(i)) begin
          r_to[i]    <= '0;
          r_valid[i] <= w_pat_legal;
          if (w_pat_legal) r_blank[i] <= w_pat_blank;
          if (w_pat_legal && !w_pat_blank) r_val[i] <= w_nib;
        end else if (r_to[i] != TW'(TIMEOUT_CYCLES)) begin
          r_to[i] <= r_to[i] + TW'(1);
          if (r_to[i] == TW'(TIMEOUT_CYCLES - 1)) r_valid[i] <= 1'b0;
        end
    end
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_val
    assign value[4*k +: 4] = r_val[k];
  end
  assign digit_valid = r_valid;
  assign digit_blank = r_blank;
  assign changed     = r_chg;
  assign frame_done  = r_frame;
  assign pattern_err = r_err;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and random scan stimulus; expected accept events
// are queued by a display-level model and checked by an independent monitor.
module tb_seg7_capture;
  localparam int TO  = 100;
  localparam int LAT = 12;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 1'b0, rst_n = 1'b0, extended = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic [15:0] value;
  logic [3:0] digit_valid, digit_blank;
  logic changed, frame_done, pattern_err;
  seg7_capture #(.N_DIGITS(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .extended(extended),
    .value(value), .digit_valid(digit_valid), .digit_blank(digit_blank),
    .changed(changed), .frame_done(frame_done), .pattern_err(pattern_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int t;
    logic [15:0] v;
    logic [3:0] vld, blk;
    logic err, chg, fd;
  } ev_t;
  ev_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [3:0] m_val [4];
  logic m_vld [4], m_blk [4];
  int m_last [4];
  logic [3:0] m_seen = 4'h0;
  logic m_err = 1'b0;
  logic [3:0] pa = 4'hF;
  logic [6:0] ps = 7'h7F;
  initial for (int i = 0; i < 4; i++) begin
    m_val[i] = 4'h0; m_vld[i] = 1'b0; m_blk[i] = 1'b0; m_last[i] = -1000000;
  end
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction
  function automatic logic dec(input logic [6:0] s, input logic ext, output logic [3:0] nib, output logic bl);
    nib = 4'h0;
    bl = (s == 7'h7F);
    if (bl) return 1'b1;
    if (ext) begin
      if (s == 7'h08) nib = 4'hA;
      else if (s == 7'h03) nib = 4'hB;
      else if (s == 7'h4E) nib = 4'hC;
      else return 1'b0;
      return 1'b1;
    end
    for (int i = 0; i < 16; i++)
      if (HEX[i] == s) begin
        nib = 4'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction
  // display-level model: a digit shown steadily long enough is accepted at t
  task automatic accept(input int t, input int d, input logic [6:0] s);
    ev_t e;
    logic [3:0] nib;
    logic bl, ok;
    ok = dec(s, extended, nib, bl);
    e.chg = ok && ((!bl && nib != m_val[d]) || bl != m_blk[d]);
    if (ok) begin
      m_blk[d] = bl;
      if (!bl) m_val[d] = nib;
    end else m_err = 1'b1;
    m_vld[d] = ok;
    m_last[d] = t;
    m_seen[d] = 1'b1;
    e.fd = (m_seen == 4'hF);
    if (e.fd) m_seen = 4'h0;
    for (int k = 0; k < 4; k++) begin
      e.v[4*k +: 4] = m_val[k];
      e.vld[k] = m_vld[k] && (t - m_last[k] < TO);
      e.blk[k] = m_blk[k];
    end
    e.err = m_err;
    e.t = t;
    q.push_back(e);
  endtask
  task automatic blk(input logic [3:0] a, input logic [6:0] s, input int len);
    int d;
    an = a; seg = s; pa = a; ps = s;
    d = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) d = i;
    if (len >= 8 && $countones(~a) == 1) accept(cyc + LAT, d, s);
    repeat (len) begin @(posedge clk); #1; end
  endtask
  function automatic logic [6:0] pick();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return HEX[r];
    if (r == 16) return 7'h7F;
    if (r == 17) return 7'h4E;
    return 7'($urandom);
  endfunction
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst_n) begin
      if (q.size() > 0 && q[0].t < cyc) begin
        e = q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missed_accept: event due %0d not checked, now %0d", e.t, cyc);
      end
      if (q.size() > 0 && q[0].t == cyc) begin
        e = q.pop_front();
        chk("value", 32'(value), 32'(e.v));
        chk("digit_valid", 32'(digit_valid), 32'(e.vld));
        chk("digit_blank", 32'(digit_blank), 32'(e.blk));
        chk("pattern_err", 32'(pattern_err), 32'(e.err));
        chk("changed", 32'(changed), 32'(e.chg));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end else chk("spurious_pulse", 32'({changed, frame_done}), 32'd0);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int a_t;
    logic [3:0] a;
    logic [6:0] s;
    int k, len, r1, r2;
    repeat (3) begin
      an = 4'($urandom); seg = 7'($urandom);
      @(posedge clk); #1;
    end
    chk("reset_value", 32'(value), 32'd0);
    chk("reset_valid", 32'(digit_valid), 32'd0);
    chk("reset_blank", 32'(digit_blank), 32'd0);
    chk("reset_changed", 32'(changed), 32'd0);
    chk("reset_frame", 32'(frame_done), 32'd0);
    chk("reset_err", 32'(pattern_err), 32'd0);
    rst_n = 1'b1;
    blk(4'hF, 7'h7F, 15);
    chk("idle_value", 32'(value), 32'd0);
    chk("idle_valid", 32'(digit_valid), 32'd0);
    chk("idle_err", 32'(pattern_err), 32'd0);
    blk(4'b1110, 7'h30, 20);
    blk(4'hF, 7'h7F, 5);
    for (int r = 0; r < 2; r++) begin
      blk(4'b1110, 7'h02, 16);
      blk(4'b1101, 7'h0E, 16);
      blk(4'b1011, 7'h40, 16);
      blk(4'b0111, 7'h19, 16);
    end
    blk(4'b1101, 7'h24, 5);
    blk(4'b1100, 7'h24, 1);
    blk(4'b1101, 7'h24, 20);
    extended = 1'b1;
    blk(4'b1011, 7'h4E, 16);
    blk(4'b1011, 7'h30, 16);
    blk(4'b1011, 7'h7F, 16);
    extended = 1'b0;
    a_t = cyc + LAT;
    blk(4'b1110, 7'h79, 14);
    blk(4'hF, 7'h7F, a_t + TO - 1 - cyc);
    chk("timeout_before", 32'(digit_valid[0]), 32'd1);
    blk(4'hF, 7'h7F, 1);
    chk("timeout_fall", 32'(digit_valid[0]), 32'd0);
    chk("timeout_value_kept", 32'(value[3:0]), 32'h1);
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      if (k < 6) begin
        a = ~(4'b0001 << $urandom_range(0, 3));
        s = pick();
        len = $urandom_range(0, 1) ? $urandom_range(12, 20) : $urandom_range(2, 6);
      end else if (k < 8) begin
        a = 4'hF; s = 7'($urandom); len = $urandom_range(1, 10);
      end else begin
        r1 = $urandom_range(0, 3);
        r2 = (r1 + 1 + $urandom_range(0, 2)) % 4;
        a = 4'($urandom) & ~(4'b0001 << r1) & ~(4'b0001 << r2);
        s = 7'($urandom); len = $urandom_range(1, 10);
      end
      if ({a, s} == {pa, ps}) continue;
      if ($urandom_range(0, 9) == 0) extended = ~extended;
      blk(a, s, len);
    end
    blk(4'hF, 7'h7F, 30);
    chk("pending_events", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
